// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_write_arbiter
// Description : Round-robin write arbiter in front of one shared enabled
//               register, with an optional per-requester burst lock.
// Revision    : 1.0 - initial release
// ============================================================================
module register_write_arbiter #(
    parameter  int WIDTH    = 8,
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ*WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [ID_WIDTH-1:0]        last_id,
    output logic                       locked,
    output logic [ID_WIDTH-1:0]        owner_id
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] owner_id_q, owner_id_d;
    logic [ID_WIDTH-1:0] last_id_q, last_id_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;

    logic [WIDTH-1:0]    data_arr [NUM_REQ];
    logic                rr_hit;
    logic [ID_WIDTH-1:0] rr_id;
    logic                sel_valid;
    logic [ID_WIDTH-1:0] sel_id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = wr_data[i*WIDTH +: WIDTH];
    end

    // (base + offs) mod NUM_REQ, valid for base < NUM_REQ and offs < NUM_REQ
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_WIDTH'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr_q, k)]) begin
                rr_hit = 1'b1;
                rr_id  = wrap_add(ptr_q, k);
            end
        end
    end

    // A single selection feeds both gnt and the register write.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        if (state_q == S_LOCKED) begin
            sel_valid = req[owner_id_q];
            sel_id    = owner_id_q;
        end else begin
            sel_valid = rr_hit;
            sel_id    = rr_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_id_q  <= '0;
            last_id_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_id_q  <= owner_id_d;
            last_id_q   <= last_id_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_valid && lock[sel_id]) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (!lock[owner_id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The pointer only advances on unlocked grants; bursts leave it untouched.
    always_comb begin
        ptr_d       = ptr_q;
        owner_id_d  = owner_id_q;
        last_id_d   = last_id_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (sel_valid) begin
            out_d       = data_arr[sel_id];
            out_valid_d = 1'b1;
            last_id_d   = sel_id;
            if (state_q == S_IDLE) begin
                ptr_d = wrap_add(sel_id, 1);
                if (lock[sel_id]) begin
                    owner_id_d = sel_id;
                end
            end
        end
    end

    always_comb begin
        gnt    = '0;
        locked = (state_q == S_LOCKED);
        if (!rst && sel_valid) begin
            gnt[sel_id] = 1'b1;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign last_id   = last_id_q;
    assign owner_id  = owner_id_q;

endmodule
`default_nettype wire
